// File: rtl/axis_crc32_append.sv
// Byte-wide AXI-Stream FCS inserter: forwards each frame unchanged, then appends the
// reflected, inverted CRC least-significant byte first and re-seeds for the next frame.
`timescale 1ns/1ps
module axis_crc32_append #(
  parameter int                   CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04c11db7,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT  = '1,
  parameter int                   CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int FCS_BYTES = CRC_WIDTH / 8;
  localparam int BC_W      = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FCS_BYTES - 1);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_FCS  = 1'b1;

  function automatic logic [CRC_WIDTH-1:0] reflect(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [CRC_WIDTH-1:0] POLY_REF = reflect(CRC_POLY);

  // Reflected Galois LFSR: shift right, data consumed LSB first.
  function automatic logic [CRC_WIDTH-1:0] crc_next(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [7:0]           d);
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ POLY_REF;
    end
    return r;
  endfunction

  logic [0:0]           r_state;
  logic [CRC_WIDTH-1:0] r_crc;
  logic [BC_W-1:0]      r_byte_cnt;
  logic [7:0]           r_m_tdata;
  logic                 r_m_tvalid;
  logic                 r_m_tlast;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_frame_count;

  logic                 w_load;
  logic                 w_accept;
  logic                 w_fcs_load;
  logic                 w_fcs_last;
  logic [CRC_WIDTH-1:0] w_fcs;

  assign w_load        = !r_m_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && (r_state == ST_PASS) && w_load;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_fcs_load    = (r_state == ST_FCS) && w_load;
  assign w_fcs_last    = (r_byte_cnt == LAST_IDX);
  assign w_fcs         = ~r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_PASS;
      r_crc         <= CRC_INIT;
      r_byte_cnt    <= '0;
      r_m_tdata     <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // NOTE: the busy set below intentionally overrides this clear when a new frame
      // starts in the same cycle the previous FCS leaves; the last nonblocking write wins.
      if (r_m_tvalid && m_axis_tready && r_m_tlast) r_busy <= 1'b0;

      if (w_accept) begin
        r_m_tdata  <= s_axis_tdata;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= 1'b0;
        r_crc      <= crc_next(r_crc, s_axis_tdata);
        r_busy     <= 1'b1;
        if (s_axis_tlast) begin
          r_state    <= ST_FCS;
          r_byte_cnt <= '0;
        end
      end else if (w_fcs_load) begin
        r_m_tdata  <= w_fcs[8*r_byte_cnt +: 8];
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= w_fcs_last;
        r_byte_cnt <= r_byte_cnt + BC_W'(1);
        if (w_fcs_last) begin
          r_state       <= ST_PASS;
          r_crc         <= CRC_INIT;
          r_frame_count <= r_frame_count + CNT_WIDTH'(1);
        end
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign busy          = r_busy;
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_axis_crc32_append.sv
// Self-checking bench for axis_crc32_append: known CRC-32 vectors plus randomized
// frames and backpressure scored against a table-free bytewise CRC-32 reference.
`timescale 1ns/1ps
module tb_axis_crc32_append;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;
  logic        s_tready, m_tvalid, m_tlast, busy;
  logic [7:0]  m_tdata;
  logic [15:0] fc;
  logic        s_tready2, m_tvalid2, m_tlast2, busy2;
  logic [7:0]  m_tdata2;
  logic [1:0]  fc2;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;
  int last_wait = 0;
  bit rand_ready = 1'b0;

  logic [7:0] out_q[$];
  bit         last_q[$];
  int         busy_xfers = 0;
  int         busy_cycles = 0;
  int         stab_viol = 0;
  bit         stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;

  always #5 clk = ~clk;

  axis_crc32_append dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .busy(busy), .frame_count(fc)
  );

  axis_crc32_append #(.CNT_WIDTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast2), .busy(busy2), .frame_count(fc2)
  );

  always @(negedge clk) m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Output monitor: records transfers, busy activity and AXIS hold violations.
  always @(posedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && (!m_tvalid || m_tdata !== stall_data || m_tlast !== stall_last))
        stab_viol++;
      if (m_tvalid && m_tready) begin
        out_q.push_back(m_tdata);
        last_q.push_back(m_tlast);
        if (busy) busy_xfers++;
      end
      if (busy) busy_cycles++;
      stalled    = m_tvalid && !m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
    end
  end

  function automatic logic [31:0] ref_crc(input bq_t b);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t expect_stream(input bq_t b);
    bq_t         r = b;
    logic [31:0] f = ref_crc(b);
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      s_tvalid = 1'b0;
    end
    @(negedge clk);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
    last_wait = n;
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL input_ready_timeout: byte %h never accepted, required acceptance", d);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input bq_t b, input bit gaps);
    foreach (b[i]) send_byte(b[i], i == b.size() - 1, gaps);
    exp_fc++;
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 5000 && out_q.size() < n; k++) @(negedge clk);
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL output_timeout: got %0d bytes, required %0d", out_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_q.delete(); last_q.delete();
    exp_fc = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 6;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_tvalid); end
    if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h required 00", m_tdata); end
    if (m_tlast !== 1'b0)  begin errors++; $display("FAIL rst_tlast: got %b required 0", m_tlast); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (fc !== 16'd0)      begin errors++; $display("FAIL rst_frame_count: got %0d required 0", fc); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b required 0", s_tready); end
    rst = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready: got %b required 1", s_tready); end
  endtask

  task automatic test_check_vector();
    logic [7:0] exp [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};
    bq_t v;
    for (int i = 0; i < 9; i++) v.push_back(8'h31 + 8'(i));
    out_q.delete(); last_q.delete();
    send_frame(v, 1'b0);
    idle();
    wait_outputs(13);
    for (int k = 0; k < 13 && k < out_q.size(); k++) begin
      checks += 2;
      if (out_q[k] !== exp[k]) begin errors++; $display("FAIL vec_data[%0d]: got %h required %h", k, out_q[k], exp[k]); end
      if (last_q[k] !== (k == 12)) begin errors++; $display("FAIL vec_tlast[%0d]: got %b required %b", k, last_q[k], k == 12); end
    end
    checks++;
    if (fc !== 16'(exp_fc)) begin errors++; $display("FAIL vec_frame_count: got %0d required %0d", fc, exp_fc); end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp [5] = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    bq_t v;
    v.push_back(8'h00);
    out_q.delete(); last_q.delete();
    busy_xfers = 0; busy_cycles = 0;
    send_frame(v, 1'b0);
    idle();
    wait_outputs(5);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      checks += 2;
      if (out_q[k] !== exp[k]) begin errors++; $display("FAIL one_data[%0d]: got %h required %h", k, out_q[k], exp[k]); end
      if (last_q[k] !== (k == 4)) begin errors++; $display("FAIL one_tlast[%0d]: got %b required %b", k, last_q[k], k == 4); end
    end
    checks += 5;
    if (out_q.size() != 5) begin errors++; $display("FAIL one_count: got %0d required 5", out_q.size()); end
    if (busy_xfers != 5)   begin errors++; $display("FAIL one_busy_xfers: got %0d required 5", busy_xfers); end
    if (busy_cycles != 5)  begin errors++; $display("FAIL one_busy_cycles: got %0d required 5", busy_cycles); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL one_busy_end: got %b required 0", busy); end
    if (fc !== 16'(exp_fc)) begin errors++; $display("FAIL one_frame_count: got %0d required %0d", fc, exp_fc); end
  endtask

  task automatic test_backpressure();
    bq_t frames[4];
    bq_t exp;
    for (int i = 0; i < 9; i++) frames[0].push_back(8'h31 + 8'(i));
    for (int f = 1; f < 4; f++)
      repeat ($urandom_range(1, 20)) frames[f].push_back(8'($urandom));
    out_q.delete(); last_q.delete();
    stab_viol = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      bq_t e = expect_stream(frames[f]);
      foreach (e[i]) exp.push_back(e[i]);
      send_frame(frames[f], 1'b1);
    end
    idle();
    wait_outputs(exp.size());
    rand_ready = 1'b0;
    for (int k = 0; k < exp.size() && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== exp[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h required %h", k, out_q[k], exp[k]); end
    end
    checks += 2;
    if (stab_viol != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations required 0", stab_viol); end
    if (fc !== 16'(exp_fc)) begin errors++; $display("FAIL bp_frame_count: got %0d required %0d", fc, exp_fc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fcs2 [4] = '{8'h8D, 8'hEF, 8'h02, 8'hD2};
    bq_t v, z, exp;
    for (int i = 0; i < 9; i++) v.push_back(8'h31 + 8'(i));
    z.push_back(8'h00);
    exp = expect_stream(v);
    begin
      bq_t e = expect_stream(z);
      foreach (e[i]) exp.push_back(e[i]);
    end
    out_q.delete(); last_q.delete();
    send_frame(v, 1'b0);
    send_frame(z, 1'b0);
    checks++;
    if (last_wait != 4) begin errors++; $display("FAIL b2b_ready_gap: got %0d cycles required 4", last_wait); end
    idle();
    wait_outputs(18);
    for (int k = 0; k < 18 && k < out_q.size(); k++) begin
      checks += 2;
      if (out_q[k] !== exp[k]) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", k, out_q[k], exp[k]); end
      if (last_q[k] !== (k == 12 || k == 17)) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b", k, last_q[k]); end
    end
    for (int k = 0; k < 4 && 14 + k < out_q.size(); k++) begin
      checks++;
      if (out_q[14+k] !== fcs2[k]) begin errors++; $display("FAIL b2b_fcs2[%0d]: got %h required %h", k, out_q[14+k], fcs2[k]); end
    end
  endtask

  task automatic test_reset_mid_fcs();
    logic [7:0] exp [5] = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    bq_t v, z;
    for (int i = 0; i < 9; i++) v.push_back(8'h31 + 8'(i));
    z.push_back(8'h00);
    out_q.delete(); last_q.delete();
    send_frame(v, 1'b0);
    idle();
    wait_outputs(10);
    checks++;
    if (m_tdata !== 8'h39 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL mid_fcs_position: got %h/%b required 39/1", m_tdata, m_tvalid);
    end
    rst = 1'b1;
    #1;
    checks += 4;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b required 0", m_tvalid); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    if (fc !== 16'd0)      begin errors++; $display("FAIL mid_rst_frame_count: got %0d required 0", fc); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_tready: got %b required 0", s_tready); end
    repeat (2) @(negedge clk);
    checks++;
    if (out_q.size() != 10) begin errors++; $display("FAIL mid_rst_quiet: got %0d bytes required 10", out_q.size()); end
    rst = 1'b0;
    exp_fc = 0;
    out_q.delete(); last_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL mid_rst_no_partial: got %0d bytes required 0", out_q.size()); end
    send_frame(z, 1'b0);
    idle();
    wait_outputs(5);
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== exp[k]) begin errors++; $display("FAIL mid_next_data[%0d]: got %h required %h", k, out_q[k], exp[k]); end
    end
    checks++;
    if (fc !== 16'd1) begin errors++; $display("FAIL mid_next_frame_count: got %0d required 1", fc); end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bq_t z, e;
      z.push_back(8'($urandom));
      e = expect_stream(z);
      out_q.delete(); last_q.delete();
      send_frame(z, 1'b0);
      idle();
      wait_outputs(5);
      checks += 3;
      if (fc2 !== seq[i]) begin errors++; $display("FAIL wrap_count[%0d]: got %0d required %0d", i, fc2, seq[i]); end
      if (fc !== 16'(i + 1)) begin errors++; $display("FAIL wrap_wide_count[%0d]: got %0d required %0d", i, fc, i + 1); end
      if (out_q.size() >= 5 && out_q[4] !== e[4]) begin
        errors++; $display("FAIL wrap_fcs[%0d]: got %h required %h", i, out_q[4], e[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_single_byte();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fcs();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
